branch_resolve_unit: RTL

- Parametrised, registered successor to the combinational branch comparator; resolves conditional branches and jumps in the execute stage.
- Computes the redirect PC and flags mispredictions against the front-end guess.
- Holds a 2-bit saturating-counter branch history table (BHT) that fetch reads and resolve updates.
- Keeps saturating performance counters for branches and mispredictions.

---
 rtl/branch_resolve_unit_pkg.sv | 26 ++
 rtl/branch_resolve_unit_bht.sv | 54 +++++
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Brief    : Shared encodings and constants for the branch resolve unit.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_GT  = 3'b011;
    localparam logic [2:0] CMP_LE  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    localparam logic [1:0] BR_OFF  = 2'b00;
    localparam logic [1:0] BR_JMP  = 2'b01;
    localparam logic [1:0] BR_CMP  = 2'b10;

    localparam logic [1:0]  BHT_RESET = 2'b01;
    localparam int unsigned PC_STEP   = 4;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_bht.sv
`default_nettype none
// ============================================================================
// Module   : bht_2bit
// Brief    : 2-bit saturating-counter table, combinational read, synchronous update.
// Revision : 1.0 - initial release
// ============================================================================
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_IDX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BHT_IDX-1:0] i_rd_idx,
    output logic               o_rd_taken,
    input  logic               i_upd_en,
    input  logic [BHT_IDX-1:0] i_upd_idx,
    input  logic               i_upd_taken
);

    localparam int ENTRIES = 2 ** BHT_IDX;

    logic [1:0] w_ctr_vec [ENTRIES];

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic [1:0] r_ctr_q;
            logic [1:0] w_ctr_d;

            always_comb begin
                w_ctr_d = r_ctr_q;
                if (i_upd_en && (i_upd_idx == BHT_IDX'(i))) begin
                    if (i_upd_taken) begin
                        if (r_ctr_q != 2'b11) w_ctr_d = r_ctr_q + 2'd1;
                    end else begin
                        if (r_ctr_q != 2'b00) w_ctr_d = r_ctr_q - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) r_ctr_q <= BHT_RESET;
                else     r_ctr_q <= w_ctr_d;
            end

            assign w_ctr_vec[i] = r_ctr_q;
        end
    endgenerate

    // Reads see the stored value only; an update in the same cycle is not bypassed.
    assign o_rd_taken = w_ctr_vec[i_rd_idx][1];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Registered branch resolver with redirect, mispredict, BHT and counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int N       = 32,
    parameter int BHT_IDX = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               InValid,
    input  logic [2:0]         CmpType,
    input  logic [1:0]         CmpEn_J_Off,
    input  logic [N-1:0]       Rs1,
    input  logic [N-1:0]       Rs2,
    input  logic [N-1:0]       Pc,
    input  logic [N-1:0]       Imm,
    input  logic               PredTaken,
    input  logic               Flush,
    input  logic [BHT_IDX-1:0] LookupIdx,
    output logic               LookupTaken,
    output logic               OutValid,
    output logic               Taken,
    output logic [N-1:0]       Redirect,
    output logic               Mispredict,
    output logic [CNT_W-1:0]   BranchCnt,
    output logic [CNT_W-1:0]   MissCnt
);

    logic             w_accept;
    logic             w_is_cmp;
    logic             w_cmp_true;
    logic             w_taken;
    logic             w_miss;
    logic [N-1:0]     w_target;
    logic [N-1:0]     w_seq_pc;

    logic             r_valid_q,      w_valid_d;
    logic             r_taken_q,      w_taken_d;
    logic             r_misp_q,       w_misp_d;
    logic [N-1:0]     r_redirect_q,   w_redirect_d;
    logic [CNT_W-1:0] r_branch_cnt_q, w_branch_cnt_d;
    logic [CNT_W-1:0] r_miss_cnt_q,   w_miss_cnt_d;

    assign w_accept = InValid && !Flush;
    assign w_is_cmp = (CmpEn_J_Off == BR_CMP);
    assign w_target = Pc + Imm;
    assign w_seq_pc = Pc + N'(PC_STEP);

    always_comb begin
        w_cmp_true = 1'b0;
        case (CmpType)
            CMP_EQ:  w_cmp_true = (Rs1 == Rs2);
            CMP_NE:  w_cmp_true = (Rs1 != Rs2);
            CMP_LT:  w_cmp_true = ($signed(Rs1) <  $signed(Rs2));
            CMP_GT:  w_cmp_true = ($signed(Rs1) >  $signed(Rs2));
            CMP_LE:  w_cmp_true = ($signed(Rs1) <= $signed(Rs2));
            CMP_GE:  w_cmp_true = ($signed(Rs1) >= $signed(Rs2));
            CMP_LTU: w_cmp_true = (Rs1 <  Rs2);
            CMP_GEU: w_cmp_true = (Rs1 >= Rs2);
            default: w_cmp_true = 1'b0;
        endcase
    end

    // The reserved encoding resolves not-taken but is still a valid op for mispredict.
    always_comb begin
        w_taken = 1'b0;
        case (CmpEn_J_Off)
            BR_CMP:  w_taken = w_cmp_true;
            BR_JMP:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_miss = (w_taken != PredTaken);

    always_comb begin
        w_valid_d      = w_accept;
        w_taken_d      = w_accept && w_taken;
        w_misp_d       = w_accept && w_miss;
        w_redirect_d   = r_redirect_q;
        w_branch_cnt_d = r_branch_cnt_q;
        w_miss_cnt_d   = r_miss_cnt_q;
        if (w_accept) begin
            w_redirect_d = w_taken ? w_target : w_seq_pc;
            if (w_is_cmp && (r_branch_cnt_q != {CNT_W{1'b1}}))
                w_branch_cnt_d = r_branch_cnt_q + CNT_W'(1);
            if (w_miss && (r_miss_cnt_q != {CNT_W{1'b1}}))
                w_miss_cnt_d = r_miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q      <= 1'b0;
            r_taken_q      <= 1'b0;
            r_misp_q       <= 1'b0;
            r_redirect_q   <= '0;
            r_branch_cnt_q <= '0;
            r_miss_cnt_q   <= '0;
        end else begin
            r_valid_q      <= w_valid_d;
            r_taken_q      <= w_taken_d;
            r_misp_q       <= w_misp_d;
            r_redirect_q   <= w_redirect_d;
            r_branch_cnt_q <= w_branch_cnt_d;
            r_miss_cnt_q   <= w_miss_cnt_d;
        end
    end

    bht_2bit #(
        .BHT_IDX (BHT_IDX)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (LookupIdx),
        .o_rd_taken  (LookupTaken),
        .i_upd_en    (w_accept && w_is_cmp),
        .i_upd_idx   (Pc[BHT_IDX+1:2]),
        .i_upd_taken (w_taken)
    );

    assign OutValid   = r_valid_q;
    assign Taken      = r_taken_q;
    assign Mispredict = r_misp_q;
    assign Redirect   = r_redirect_q;
    assign BranchCnt  = r_branch_cnt_q;
    assign MissCnt    = r_miss_cnt_q;

endmodule
`default_nettype wire
